// File: rtl/iob_eth_tx.sv
// iob_eth_tx: MII transmitter (preamble, SFD, payload, optional pad, CRC-32 FCS, inter-frame gap).
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME bytes before the FCS.
module iob_eth_tx #(
`ifdef ETH_TX_PAD_EN
    parameter int MIN_FRAME = 60,
`endif
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24
) (
    input  logic        TX_CLK,
    input  logic        rx_rstn,
    input  logic        send,
    input  logic [10:0] nbytes,
    output logic [10:0] addr,
    input  logic [7:0]  data,
    output logic        TX_EN,
    output logic [3:0]  TX_DATA,
    output logic        ready
);
`ifdef ETH_TX_PAD_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, CRC, IFG} state_t;
`else
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, CRC, IFG} state_t;
`endif
    state_t state, state_n, tail;
    logic [7:0] cnt, cnt_n;
    logic half, half_n;
    logic [10:0] len, len_n, byte_cnt, byte_n, addr_n, step;
    logic [7:0] hold, hold_n;
    logic [31:0] crc, crc_n, fcs;
    logic ready_n, last_byte;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign fcs = ~crc;
    assign last_byte = {1'b0, byte_cnt} + 12'd1 == {1'b0, len};
    // addr stops at len-1 and holds there until the next frame
    assign step = ({1'b0, addr} + 12'd1 < {1'b0, len}) ? addr + 11'd1 : addr;
`ifdef ETH_TX_PAD_EN
    assign tail = ({1'b0, len} < 12'(MIN_FRAME)) ? PAD : CRC;
`else
    assign tail = CRC;
`endif

    always_ff @(negedge TX_CLK or negedge rx_rstn) begin
        if (!rx_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            half     <= 1'b0;
            len      <= '0;
            byte_cnt <= '0;
            hold     <= '0;
            crc      <= '1;
            addr     <= '0;
            ready    <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            half     <= half_n;
            len      <= len_n;
            byte_cnt <= byte_n;
            hold     <= hold_n;
            crc      <= crc_n;
            addr     <= addr_n;
            ready    <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half;
        len_n   = len;
        byte_n  = byte_cnt;
        hold_n  = hold;
        crc_n   = crc;
        addr_n  = addr;
        ready_n = ready;
        case (state)
            IDLE: if (send && ready) begin
                len_n   = nbytes;
                byte_n  = '0;
                addr_n  = '0;
                ready_n = 1'b0;
                crc_n   = '1;
                cnt_n   = '0;
                state_n = PREAMBLE;
            end
            PREAMBLE: begin
                cnt_n   = cnt == 8'(PREAMBLE_NIBBLES - 1) ? '0 : cnt + 8'd1;
                state_n = cnt == 8'(PREAMBLE_NIBBLES - 1) ? SFD : PREAMBLE;
            end
            SFD: begin
                half_n  = 1'b0;
                state_n = len == '0 ? tail : DATA;
                hold_n  = len == '0 ? hold : data;
                addr_n  = len == '0 ? addr : step;
            end
            // byte is latched entering its low nibble; CRC absorbs it leaving the high nibble
            DATA: begin
                half_n = ~half;
                if (half) begin
                    crc_n   = crc8(crc, hold);
                    byte_n  = byte_cnt + 11'd1;
                    state_n = last_byte ? tail : DATA;
                    hold_n  = last_byte ? hold : data;
                    addr_n  = last_byte ? addr : step;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                half_n = ~half;
                if (half) begin
                    crc_n   = crc8(crc, 8'h00);
                    byte_n  = byte_cnt + 11'd1;
                    state_n = {1'b0, byte_cnt} + 12'd1 == 12'(MIN_FRAME) ? CRC : PAD;
                end
            end
`endif
            CRC: begin
                cnt_n   = cnt[2:0] == 3'd7 ? '0 : cnt + 8'd1;
                state_n = cnt[2:0] == 3'd7 ? IFG : CRC;
            end
            // the IDLE cycle that samples send is the last gap nibble
            IFG: begin
                cnt_n   = cnt == 8'(IFG_NIBBLES - 2) ? '0 : cnt + 8'd1;
                ready_n = cnt == 8'(IFG_NIBBLES - 2);
                state_n = cnt == 8'(IFG_NIBBLES - 2) ? IDLE : IFG;
            end
            default: state_n = IDLE;
        endcase
    end

    assign TX_EN = state != IDLE && state != IFG;
    assign TX_DATA = state == PREAMBLE ? 4'h5 :
                     state == SFD      ? 4'hD :
                     state == DATA     ? (half ? hold[7:4] : hold[3:0]) :
                     state == CRC      ? fcs[{cnt[2:0], 2'b00} +: 4] : 4'h0;
endmodule

// File: tb/tb_iob_eth_tx.sv
// tb_iob_eth_tx: frame-level checks of iob_eth_tx against a queue/table CRC model.
module tb_iob_eth_tx;
    localparam int PRE = 15;
    localparam int IFG = 24;
`ifdef ETH_TX_PAD_EN
    localparam int MINF = 60;
`else
    localparam int MINF = 0;
`endif
    localparam int LIMIT = 5000;

    typedef struct { int n; int en; } vec_t;

    logic        TX_CLK = 1'b0;
    logic        rx_rstn = 1'b0;
    logic        send = 1'b0;
    logic [10:0] nbytes = '0;
    logic [10:0] addr;
    logic [7:0]  data = '0;
    logic        TX_EN;
    logic [3:0]  TX_DATA;
    logic        ready;

    logic [7:0]  mem [2048];
    logic [31:0] tab [256];
    logic [3:0]  got [$];
    logic [3:0]  exp_q [$];
    int checks = 0, errors = 0, en_cycles, rdy_wait, max_addr;

    iob_eth_tx dut (
        .TX_CLK(TX_CLK), .rx_rstn(rx_rstn), .send(send), .nbytes(nbytes), .addr(addr),
        .data(data), .TX_EN(TX_EN), .TX_DATA(TX_DATA), .ready(ready)
    );

    always #5 TX_CLK = ~TX_CLK;
    always @(posedge TX_CLK) data <= mem[addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input logic [7:0] b [$]);
        logic [31:0] c;
        c = '1;
        foreach (b[i]) c = (c >> 8) ^ tab[c[7:0] ^ b[i]];
        return c;
    endfunction

    function automatic void build_exp(input int n);
        logic [7:0] b [$];
        logic [31:0] f;
        exp_q.delete();
        for (int i = 0; i < n; i++) b.push_back(mem[i]);
        while (b.size() < MINF) b.push_back(8'h00);
        f = ~crc_bytes(b);
        repeat (PRE) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (b[i]) begin
            exp_q.push_back(b[i][3:0]);
            exp_q.push_back(b[i][7:4]);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(f[4*i +: 4]);
    endfunction

    // Collect nibbles while TX_EN is high, then count gap cycles until ready returns.
    task automatic capture();
        int t;
        t = 0;
        got.delete();
        en_cycles = 0;
        rdy_wait = 0;
        max_addr = 0;
        while (!TX_EN && t < LIMIT) begin @(posedge TX_CLK); t++; end
        while (TX_EN && t < LIMIT) begin
            got.push_back(TX_DATA);
            en_cycles++;
            if (int'(addr) > max_addr) max_addr = int'(addr);
            @(posedge TX_CLK);
            t++;
        end
        while (!ready && t < LIMIT) begin rdy_wait++; @(posedge TX_CLK); t++; end
        chk("capture_in_time", t < LIMIT, 1);
    endtask

    task automatic check_frame(input string tag, input int n, input int en_exp);
        logic [7:0] b [$];
        int d;
        d = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) begin d = i; break; end
        for (int i = PRE + 1; i + 1 < got.size(); i += 2) b.push_back({got[i+1], got[i]});
        chk({tag, "_en_cycles"}, en_cycles, en_exp < 0 ? exp_q.size() : en_exp);
        chk({tag, "_stream_match_len"}, d, exp_q.size());
        chk({tag, "_crc_residue"}, crc_bytes(b), 32'hDEBB20E3);
        chk({tag, "_ifg_wait"}, rdy_wait, IFG - 1);
        chk({tag, "_max_addr"}, max_addr, n == 0 ? 0 : n - 1);
    endtask

    task automatic frame(input string tag, input int n, input int en_exp, input bit rnd);
        for (int i = 0; i < n; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
        build_exp(n);
        nbytes = 11'(n);
        send = 1'b1;
        @(posedge TX_CLK);
        send = 1'b0;
        capture();
        check_frame(tag, n, en_exp);
    endtask

    initial begin
        vec_t vecs [6];
        int g, t, seen;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = 32'(i);
            for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
            tab[i] = r;
        end
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        repeat (3) @(posedge TX_CLK);
        chk("rst_tx_en", TX_EN, 0);
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_ready", ready, 1);
        chk("rst_addr", addr, 0);
        #2 rx_rstn = 1'b1;
        repeat (10) begin
            @(posedge TX_CLK);
            chk("idle_tx_en", TX_EN, 0);
            chk("idle_ready", ready, 1);
            chk("idle_addr", addr, 0);
        end

`ifdef ETH_TX_PAD_EN
        vecs = '{'{64, 152}, '{20, 144}, '{0, 144}, '{1, 144}, '{60, 144}, '{61, 146}};
`else
        vecs = '{'{64, 152}, '{20, 64}, '{0, 24}, '{1, 26}, '{60, 144}, '{61, 146}};
`endif
        foreach (vecs[i]) frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].en, i != 0);

        repeat (8) frame("rand", int'($urandom_range(0, 150)), -1, 1'b1);

        // send and nbytes changes while busy must not disturb or queue anything
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        build_exp(64);
        nbytes = 11'd64;
        send = 1'b1;
        @(posedge TX_CLK);
        send = 1'b0;
        fork
            capture();
            begin
                repeat (40) @(posedge TX_CLK);
                send = 1'b1;
                nbytes = 11'd5;
                @(posedge TX_CLK);
                send = 1'b0;
            end
        join
        check_frame("busy_send", 64, 152);
        seen = 0;
        repeat (30) begin @(posedge TX_CLK); if (TX_EN) seen++; end
        chk("busy_send_not_queued", seen, 0);

        // send held high: exactly two frames separated by the full gap
        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom);
        build_exp(10);
        nbytes = 11'd10;
        send = 1'b1;
        @(posedge TX_CLK);
        capture();
        check_frame("held1", 10, -1);
        g = 0;
        t = 0;
        while (!TX_EN && t < 100) begin g++; @(posedge TX_CLK); t++; end
        chk("held_gap", rdy_wait + g, IFG);
        send = 1'b0;
        capture();
        check_frame("held2", 10, -1);

        // reset in byte 30 of a 64-byte frame
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        nbytes = 11'd64;
        send = 1'b1;
        @(posedge TX_CLK);
        send = 1'b0;
        repeat (16 + 60) @(posedge TX_CLK);
        chk("midrst_busy_before", TX_EN, 1);
        #2 rx_rstn = 1'b0;
        #1;
        chk("midrst_tx_en", TX_EN, 0);
        chk("midrst_tx_data", TX_DATA, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_addr", addr, 0);
        @(posedge TX_CLK);
        #2 rx_rstn = 1'b1;
        @(posedge TX_CLK);
        frame("after_rst", 64, 152, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iob_eth_tx.md
Name: iob_eth_tx

Overview:
- MII transmitter for the Ethernet core.
- When the CPU side pulses send, the block reads a frame of nbytes bytes from the TX frame buffer and serialises it onto the 4-bit MII.
- Transmit sequence: preamble, SFD, payload, optional pad, then the CRC-32 FCS it computes itself, followed by the inter-frame gap.
- Runs entirely in the TX_CLK domain; sits beside the receiver, between the TX buffer and the PHY.

Parameters:
- PREAMBLE_NIBBLES, 15, count of 0x5 nibbles sent before the SFD nibble 0xD.
- IFG_NIBBLES, 24, idle TX_CLK cycles after the FCS before ready reasserts (96 bit times).
- MIN_FRAME, 60, minimum byte count before the FCS (used only with padding enabled).

Ports:
- TX_CLK  input  1  MII transmit clock, 25/2.5 MHz from the PHY.
- rx_rstn  input  1  reset, asynchronous, active-low; already synchronised to TX_CLK by the caller.
- send  input  1  start request; sampled when ready=1.
- nbytes  input  11  frame length excluding FCS (dest MAC through payload); captured on send.
- addr  output  11  TX buffer read address.
- data  input  8  TX buffer read data; valid 1 TX_CLK cycle after addr changes.
- TX_EN  output  1  MII transmit enable.
- TX_DATA  output  4  MII transmit nibble.
- ready  output  1  1 = idle and able to accept send.

Behaviour:
- Clocking:
  - All state, TX_EN and TX_DATA update on negedge TX_CLK, giving the PHY a half cycle of setup for its posedge sample.
  - Reset and all registers are asynchronous to rx_rstn.
- Reset values: TX_EN=0, TX_DATA=0, addr=0, ready=1, state=IDLE, CRC register=32'hFFFFFFFF.
- State machine (one nibble per cycle):
  - IDLE: TX_EN=0. On send with ready=1:
    - latch nbytes into len and clear byte_cnt;
    - set addr=0, ready=0, CRC=FFFFFFFF;
    - go to PREAMBLE.
  - PREAMBLE: TX_EN=1, TX_DATA=4'h5 for PREAMBLE_NIBBLES cycles, then go to SFD.
  - SFD: TX_DATA=4'hD for one cycle, then go to DATA. By now addr=0 has been stable for at least 2 cycles, so data holds byte 0.
  - DATA: each byte takes two cycles, low nibble first, then high nibble.
    - The byte is latched into a holding register in the low-nibble cycle.
    - addr increments in the same cycle, so the next byte is valid before its low nibble.
    - CRC is updated over the full latched byte in the high-nibble cycle.
    - After the high nibble of byte len-1, go to PAD (if needed, see Optional Feature) or CRC.
  - CRC: 8 nibbles of ~CRC, sent in bit order [3:0], [7:4] … [31:28], i.e. FCS byte 0 first, low nibble first. Then go to IFG.
  - IFG: TX_EN=0, TX_DATA=0 for IFG_NIBBLES cycles; then ready=1, go to IDLE.
- CRC arithmetic:
  - IEEE 802.3 CRC-32, reflected polynomial 32'hEDB88320, init all-ones, output complemented.
  - Covers the destination MAC through the last payload/pad byte.
- Boundary conditions:
  - send while ready=0: ignored, no queuing.
  - send held high: only one frame starts; a new frame starts only if send is still high when ready returns to 1.
  - nbytes=0: block goes PREAMBLE, SFD, then pad or CRC directly; no buffer reads are used.
  - nbytes > 2047: not representable; len is taken modulo 2048 by width.
  - addr never exceeds len-1. After the last byte it holds its value until the next send.
  - nbytes, addr and data changes outside IDLE do not disturb the frame in progress, because len and the data byte are latched.
  - Reset mid-frame: TX_EN drops to 0 immediately (asynchronous), the frame is truncated, and ready=1 after reset release.

Optional Feature:
- Macro: ETH_TX_PAD_EN.
- Defined: if len < MIN_FRAME, after the last buffer byte the block sends 0x00 bytes (included in the CRC) until MIN_FRAME bytes have been sent; addr does not advance during padding.
- Undefined: no PAD state; the FCS follows the last buffer byte, so short frames are emitted short.

Test Plan:
- Reset, then idle 10 cycles -> TX_EN=0, ready=1, addr=0 throughout.
- send with nbytes=64, buffer[i]=i -> 15×0x5 nibbles then 0xD; nibbles 0,0,1,0,2,0…; 128 data nibbles; 8 FCS nibbles matching the bench CRC-32 model; TX_EN high for 152 cycles; ready after 24 more cycles.
- Loopback of the 64-byte frame into the receive path with a matching MAC -> frame accepted, CRC residue check passes.
- nbytes=20 with ETH_TX_PAD_EN defined -> 40 zero pad bytes, 60 bytes before FCS, FCS over padded data. Same test with the macro undefined -> 20 bytes then FCS.
- send pulsed during DATA of a frame, and send held high across two frames -> first frame unaffected, second starts only after the IFG; bench counts exactly 24 idle cycles between frames.
- rx_rstn asserted at byte 30 of a 64-byte frame -> TX_EN=0 at once; after release ready=1 and a fresh send produces a correct full frame.
